// File: rtl/pattern_pkg.sv
// pattern_pkg: frame pattern and FSM encoding shared by the
// pattern transmitter and the detector.
package pattern_pkg;

  localparam int PAT_LEN = 5;
  localparam logic [PAT_LEN-1:0] PATTERN = 5'b10010;
  localparam int BIT_W = $clog2(PAT_LEN);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_SEND = 4'b0010,
    S_GAP  = 4'b0100,
    S_FIN  = 4'b1000
  } state_t;

endpackage

// File: rtl/pattern_tx.sv
// pattern_tx: emits N pattern frames MSB first with zero-gap runs.
// Optional PATTERN_TX_READY_EN adds a ready input that stalls transmission.
module pattern_tx
  import pattern_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PATTERN_TX_READY_EN
  input  logic             ready,
`endif
  input  logic             start,
  input  logic [CNT_W-1:0] frames,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(PAT_LEN - 1);

  state_t           r_state, w_nxt;
  logic [BIT_W-1:0] r_bit, w_bit;
  logic [CNT_W-1:0] r_frm, w_frm;
  logic [GAP_W-1:0] r_gap_len, w_gap_len;
  logic [GAP_W-1:0] r_gcnt, w_gcnt;
  logic             r_out, r_valid, r_busy, r_done;
  logic             w_rdy, w_act, w_adv, w_nxt_act;

`ifdef PATTERN_TX_READY_EN
  assign w_rdy = ready;
`else
  assign w_rdy = 1'b1;
`endif

  // State names the bit on the line; a stall holds it and drops valid.
  assign w_act     = (r_state == S_SEND) || (r_state == S_GAP);
  assign w_adv     = w_rdy || !w_act;
  assign w_nxt_act = (w_nxt == S_SEND) || (w_nxt == S_GAP);

  always_comb begin
    w_nxt     = r_state;
    w_bit     = r_bit;
    w_frm     = r_frm;
    w_gap_len = r_gap_len;
    w_gcnt    = r_gcnt;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (frames != '0) begin
            w_nxt     = S_SEND;
            w_bit     = BIT_TOP;
            w_frm     = frames;
            w_gap_len = gap;
          end else begin
            w_nxt = S_FIN;
          end
        end
      end
      S_SEND: begin
        if (w_rdy) begin
          if (r_bit != '0) begin
            w_bit = r_bit - 1'b1;
          end else begin
            w_frm = r_frm - 1'b1;
            if (r_frm == CNT_W'(1)) begin
              w_nxt = S_FIN;
            end else if (r_gap_len != '0) begin
              w_nxt  = S_GAP;
              w_gcnt = r_gap_len;
            end else begin
              w_bit = BIT_TOP;
            end
          end
        end
      end
      S_GAP: begin
        if (w_rdy) begin
          if (r_gcnt == GAP_W'(1)) begin
            w_nxt  = S_SEND;
            w_bit  = BIT_TOP;
            w_gcnt = '0;
          end else begin
            w_gcnt = r_gcnt - 1'b1;
          end
        end
      end
      S_FIN:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit     <= '0;
      r_frm     <= '0;
      r_gap_len <= '0;
      r_gcnt    <= '0;
      r_out     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_bit     <= w_bit;
      r_frm     <= w_frm;
      r_gap_len <= w_gap_len;
      r_gcnt    <= w_gcnt;
      if (w_adv) begin
        r_valid <= w_nxt_act;
        r_out   <= (w_nxt == S_SEND) && PATTERN[w_bit];
      end else begin
        r_valid <= 1'b0;
      end
      r_busy <= w_nxt_act;
      r_done <= (w_nxt == S_FIN);
    end
  end

  assign out   = r_out;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: table, random and corner-case checks of pattern_tx
// against a queue-based stream model.
module tb_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic       start;
  logic [7:0] frames;
  logic [3:0] gap;
  logic       out, valid, busy, done;

  int checks   = 0;
  int failures = 0;

  bit got_q[$];
  bit exp_q[$];
  int first_v, last_v, done_cyc, n_done, busy_err, n_valid;

  typedef struct {
    int fr;
    int gp;
    int cnt;
    int hits;
  } vec_t;
  vec_t tbl[7];

  pattern_tx dut (
    .clk(clk),
    .rst(rst),
`ifdef PATTERN_TX_READY_EN
    .ready(ready),
`endif
    .start(start),
    .frames(frames),
    .gap(gap),
    .out(out),
    .valid(valid),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic build_exp(input int fr, input int gp);
    logic [4:0] p;
    p = 5'b10010;
    exp_q.delete();
    for (int f = 0; f < fr; f++) begin
      for (int b = 4; b >= 0; b--) exp_q.push_back(p[b]);
      if (f < fr - 1)
        for (int g = 0; g < gp; g++) exp_q.push_back(1'b0);
    end
  endtask

  function automatic int count_hits();
    logic [4:0] w;
    int n;
    w = '0;
    n = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      w = {w[3:0], got_q[i]};
      if (i >= 4 && w == 5'b10010) n++;
    end
    return n;
  endfunction

  task automatic run_xfer(input int fr, input int gp, input int rep,
                          input int rdy_at, input int rdy_len);
    int c;
    int tail;
    bit fin;
    got_q.delete();
    first_v = 0; last_v = 0; done_cyc = 0;
    n_done = 0; busy_err = 0; n_valid = 0;
    c = 0; tail = 0; fin = 0;
    @(negedge clk);
    frames = 8'(fr);
    gap    = 4'(gp);
    start  = 1'b1;
    while (!fin) begin
      @(negedge clk);
      c++;
      if (valid) begin
        got_q.push_back(out);
        n_valid++;
        if (first_v == 0) first_v = c;
        last_v = c;
        if (!busy) busy_err++;
      end
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
        if (busy) busy_err++;
      end
      start = (rep != 0 && c == rep);
      if (start) frames = 8'd9;
      ready = !(c >= rdy_at && c < rdy_at + rdy_len);
      if (n_done > 0) tail++;
      if (tail == 4) fin = 1;
      if (c >= 6000 && !fin) begin
        chk("timeout", c, 0);
        fin = 1;
      end
    end
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic check_xfer(input string tag, input int fr, input int gp,
                            input int exp_cnt, input int rdy_len);
    int mism;
    build_exp(fr, gp);
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] != exp_q[i]) mism++;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    chk({tag, "_bits"}, mism, 0);
    chk({tag, "_vcnt"}, n_valid, exp_cnt);
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_donecyc"}, done_cyc, (fr == 0) ? 1 : exp_cnt + 1 + rdy_len);
    chk({tag, "_first"}, first_v, (fr == 0) ? 0 : 1);
    chk({tag, "_busy"}, busy_err, 0);
  endtask

  initial begin
    int n;
    int fr, gp;
    rst = 1'b1; ready = 1'b1; start = 1'b0;
    frames = '0; gap = '0;
    tbl[0] = '{1, 0, 5, 1};
    tbl[1] = '{3, 2, 19, 3};
    tbl[2] = '{0, 0, 0, 0};
    tbl[3] = '{2, 0, 10, 2};
    tbl[4] = '{2, 1, 11, 3};
    tbl[5] = '{4, 15, 65, 4};
    tbl[6] = '{255, 15, 5085, 255};

    repeat (3) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      run_xfer(tbl[i].fr, tbl[i].gp, 0, 0, 0);
      check_xfer($sformatf("tbl%0d", i), tbl[i].fr, tbl[i].gp,
                 tbl[i].cnt, 0);
      chk($sformatf("tbl%0d_hits", i), count_hits(), tbl[i].hits);
    end

    run_xfer(2, 0, 3, 0, 0);
    check_xfer("ign_start", 2, 0, 10, 0);

    @(negedge clk);
    frames = 8'd3; gap = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_valid_pre", valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out", out, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || valid) n++;
    end
    chk("mid_quiet", n, 0);
    run_xfer(1, 0, 0, 0, 0);
    check_xfer("after_rst", 1, 0, 5, 0);

    for (int t = 0; t < 20; t++) begin
      fr = $urandom_range(0, 12);
      gp = $urandom_range(0, 15);
      run_xfer(fr, gp, 0, 0, 0);
      check_xfer($sformatf("rnd%0d", t), fr, gp,
                 (fr == 0) ? 0 : fr * 5 + (fr - 1) * gp, 0);
    end

`ifdef PATTERN_TX_READY_EN
    run_xfer(1, 0, 0, 1, 3);
    check_xfer("rdy_one", 1, 0, 5, 3);
    run_xfer(3, 2, 0, 7, 2);
    check_xfer("rdy_gap", 3, 2, 19, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
